// File: rtl/ex_wb_stage.sv
// rtl/ex_wb_stage.sv - EX completion stage: data-memory handshake, register writeback, PC redirect.
// Optional macro EX_WB_MEM_TIMEOUT_EN adds a memory-wait abort counter and a mem_timeout pulse.
module ex_wb_stage #(
    parameter int RD_W           = 6,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            regWriteEX,
    input  logic            memToRegEX,
    input  logic            MemReadEX,
    input  logic            MemWriteEX,
    input  logic            JumpEX,
    input  logic            JumpMemEX,
    input  logic            BranchZeroEX,
    input  logic            BranchNegEX,
    input  logic            SavePCEX,
    input  logic [31:0]     PCEX,
    input  logic [31:0]     rsEX,
    input  logic [31:0]     rtEX,
    input  logic [31:0]     immediateEX,
    input  logic [RD_W-1:0] rdEX,
    input  logic [31:0]     alu_result,
    input  logic            alu_zero,
    input  logic            alu_neg,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic            mem_ready,
    input  logic [31:0]     mem_rdata,
    output logic            wb_en,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            pc_redirect,
    output logic [31:0]     pc_target,
`ifdef EX_WB_MEM_TIMEOUT_EN
    output logic            mem_timeout,
`endif
    output logic            stall
);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB} state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic              wb_en_q, wb_en_d, pc_redirect_q, pc_redirect_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d, pc_target_q, pc_target_d;
    // Bundle fields still needed once the memory access completes
    logic              reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d;
    logic              jump_mem_q, jump_mem_d;
    logic [31:0]       alu_q, alu_d;

`ifdef EX_WB_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
`else
    logic              unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        wb_en_d       = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        pc_redirect_d = 1'b0;
        pc_target_d   = pc_target_q;
        reg_write_d   = reg_write_q;
        mem_to_reg_d  = mem_to_reg_q;
        jump_mem_d    = jump_mem_q;
        alu_d         = alu_q;
`ifdef EX_WB_MEM_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    wb_rd_d = rdEX;
                    if (MemReadEX || MemWriteEX || JumpMemEX) begin
                        state_d      = S_MEM;
                        mem_req_d    = 1'b1;
                        mem_we_d     = MemWriteEX;
                        mem_addr_d   = JumpMemEX ? rsEX : alu_result;
                        mem_wdata_d  = rtEX;
                        reg_write_d  = regWriteEX;
                        mem_to_reg_d = memToRegEX;
                        jump_mem_d   = JumpMemEX;
                        alu_d        = alu_result;
`ifdef EX_WB_MEM_TIMEOUT_EN
                        cnt_d        = '0;
`endif
                    end else begin
                        wb_en_d       = regWriteEX;
                        wb_data_d     = SavePCEX ? (PCEX + immediateEX) : alu_result;
                        pc_redirect_d = JumpEX | (BranchZeroEX & alu_zero) | (BranchNegEX & alu_neg);
                        pc_target_d   = rsEX;
                    end
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d   = S_WB;
                    mem_req_d = 1'b0;
                    wb_en_d   = reg_write_q;
                    wb_data_d = mem_to_reg_q ? mem_rdata : alu_q;
                    if (jump_mem_q) begin
                        pc_redirect_d = 1'b1;
                        pc_target_d   = mem_rdata;
                    end
                end
`ifdef EX_WB_MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            wb_en_q       <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            pc_redirect_q <= 1'b0;
            pc_target_q   <= '0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            jump_mem_q    <= 1'b0;
            alu_q         <= '0;
`ifdef EX_WB_MEM_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            wb_en_q       <= wb_en_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            pc_redirect_q <= pc_redirect_d;
            pc_target_q   <= pc_target_d;
            reg_write_q   <= reg_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            jump_mem_q    <= jump_mem_d;
            alu_q         <= alu_d;
`ifdef EX_WB_MEM_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wb_en       = wb_en_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign pc_redirect = pc_redirect_q;
    assign pc_target   = pc_target_q;
    assign stall       = (state_q != S_IDLE);
`ifdef EX_WB_MEM_TIMEOUT_EN
    assign mem_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// tb/tb_ex_wb_stage.sv - randomized self-checking bench for ex_wb_stage against a behavioural model.
module tb_ex_wb_stage;
    localparam int RD_W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ex_valid, regWriteEX, memToRegEX, MemReadEX, MemWriteEX;
    logic JumpEX, JumpMemEX, BranchZeroEX, BranchNegEX, SavePCEX;
    logic [31:0] PCEX, rsEX, rtEX, immediateEX, alu_result, mem_rdata;
    logic [RD_W-1:0] rdEX;
    logic alu_zero, alu_neg, mem_ready;
    logic mem_req, mem_we, wb_en, pc_redirect, stall;
    logic [31:0] mem_addr, mem_wdata, wb_data, pc_target;
    logic [RD_W-1:0] wb_rd;
`ifdef EX_WB_MEM_TIMEOUT_EN
    logic mem_timeout;
`endif

    ex_wb_stage #(.RD_W(RD_W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .regWriteEX(regWriteEX), .memToRegEX(memToRegEX), .MemReadEX(MemReadEX),
        .MemWriteEX(MemWriteEX), .JumpEX(JumpEX), .JumpMemEX(JumpMemEX),
        .BranchZeroEX(BranchZeroEX), .BranchNegEX(BranchNegEX), .SavePCEX(SavePCEX),
        .PCEX(PCEX), .rsEX(rsEX), .rtEX(rtEX), .immediateEX(immediateEX), .rdEX(rdEX),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .pc_redirect(pc_redirect), .pc_target(pc_target),
`ifdef EX_WB_MEM_TIMEOUT_EN
        .mem_timeout(mem_timeout),
`endif
        .stall(stall)
    );

    typedef struct {
        bit rw, m2r, mr, mw, j, jm, bz, bn, sp, z, n;
        logic [31:0] pc, rs, rt, imm, alu;
        logic [RD_W-1:0] rd;
    } instr_t;

    int errors = 0;
    int checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input instr_t t);
        ex_valid = 1'b1; regWriteEX = t.rw; memToRegEX = t.m2r; MemReadEX = t.mr;
        MemWriteEX = t.mw; JumpEX = t.j; JumpMemEX = t.jm; BranchZeroEX = t.bz;
        BranchNegEX = t.bn; SavePCEX = t.sp; alu_zero = t.z; alu_neg = t.n;
        PCEX = t.pc; rsEX = t.rs; rtEX = t.rt; immediateEX = t.imm;
        alu_result = t.alu; rdEX = t.rd;
    endtask

    function automatic instr_t blank();
        instr_t t;
        t = '{default: '0};
        return t;
    endfunction

    function automatic instr_t rand_alu();
        instr_t t;
        t = blank();
        t.rw = 1'($urandom); t.m2r = 1'($urandom); t.j = ($urandom_range(0, 3) == 0);
        t.bz = 1'($urandom); t.bn = 1'($urandom); t.sp = 1'($urandom);
        t.z = 1'($urandom); t.n = 1'($urandom);
        t.pc = $urandom; t.rs = $urandom; t.rt = $urandom; t.imm = $urandom;
        t.alu = $urandom; t.rd = RD_W'($urandom);
        return t;
    endfunction

    function automatic instr_t rand_mem();
        instr_t t;
        int kind;
        t = rand_alu();
        t.j = 0; t.bz = 0; t.bn = 0; t.sp = 0;
        kind = $urandom_range(0, 2);
        t.mr = (kind == 0); t.mw = (kind == 1); t.jm = (kind == 2);
        return t;
    endfunction

    // Non-memory instruction: results appear one cycle after issue.
    task automatic do_alu(input instr_t t, input string tag);
        logic [31:0] exp_data;
        bit exp_redir;
        exp_data  = t.sp ? t.pc + t.imm : t.alu;
        exp_redir = t.j | (t.bz & t.z) | (t.bn & t.n);
        drive(t);
        step();
        ex_valid = 1'b0;
        checks++;
        if (wb_en !== t.rw) begin
            errors++; $display("FAIL %s wb_en got=%0b exp=%0b", tag, wb_en, t.rw);
        end
        if (t.rw) begin
            checks++;
            if (wb_rd !== t.rd || wb_data !== exp_data) begin
                errors++; $display("FAIL %s wb rd/data got=%0d/%h exp=%0d/%h", tag, wb_rd, wb_data, t.rd, exp_data);
            end
        end
        checks++;
        if (pc_redirect !== exp_redir) begin
            errors++; $display("FAIL %s pc_redirect got=%0b exp=%0b", tag, pc_redirect, exp_redir);
        end
        if (exp_redir) begin
            checks++;
            if (pc_target !== t.rs) begin
                errors++; $display("FAIL %s pc_target got=%h exp=%h", tag, pc_target, t.rs);
            end
        end
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL %s stall/mem_req got=%0b/%0b exp=0/0", tag, stall, mem_req);
        end
    endtask

    // Memory instruction: mem_ready is raised on the n-th cycle of mem_req.
    task automatic do_mem(input instr_t t, input int n, input logic [31:0] rdata, input string tag);
        logic [31:0] exp_addr, exp_data;
        int high, unstable;
        exp_addr = t.jm ? t.rs : t.alu;
        exp_data = t.m2r ? rdata : t.alu;
        high = 0; unstable = 0;
        drive(t);
        step();
        checks++;
        if (stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== t.mw || mem_wdata !== t.rt) begin
            errors++;
            $display("FAIL %s request got stall=%0b req=%0b addr=%h we=%0b wd=%h exp 1/1/%h/%0b/%h",
                     tag, stall, mem_req, mem_addr, mem_we, mem_wdata, exp_addr, t.mw, t.rt);
        end
        for (int k = 1; k <= n; k++) begin
            if (mem_req === 1'b1) high++;
            if (mem_addr !== exp_addr || mem_we !== t.mw || mem_wdata !== t.rt || stall !== 1'b1 ||
                wb_en !== 1'b0 || pc_redirect !== 1'b0) unstable++;
            mem_ready = (k == n);
            mem_rdata = (k == n) ? rdata : $urandom;
            ex_valid  = 1'($urandom);
            step();
        end
        mem_ready = 1'b0; ex_valid = 1'b0; mem_rdata = $urandom;
        checks++;
        if (high != n || unstable != 0) begin
            errors++; $display("FAIL %s mem wait got high=%0d unstable=%0d exp high=%0d unstable=0", tag, high, unstable, n);
        end
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b1 || wb_en !== t.rw || pc_redirect !== t.jm) begin
            errors++;
            $display("FAIL %s wb cycle got req=%0b stall=%0b wb_en=%0b redir=%0b exp 0/1/%0b/%0b",
                     tag, mem_req, stall, wb_en, pc_redirect, t.rw, t.jm);
        end
        if (t.rw) begin
            checks++;
            if (wb_data !== exp_data || wb_rd !== t.rd) begin
                errors++; $display("FAIL %s wb rd/data got=%0d/%h exp=%0d/%h", tag, wb_rd, wb_data, t.rd, exp_data);
            end
        end
        if (t.jm) begin
            checks++;
            if (pc_target !== rdata) begin
                errors++; $display("FAIL %s pc_target got=%h exp=%h", tag, pc_target, rdata);
            end
        end
        step();
        checks++;
        if (stall !== 1'b0 || wb_en !== 1'b0 || pc_redirect !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s return idle got stall=%0b wb_en=%0b redir=%0b req=%0b exp 0/0/0/0",
                     tag, stall, wb_en, pc_redirect, mem_req);
        end
    endtask

    task automatic check_quiet(input string tag);
        checks++;
        if (wb_en !== 1'b0 || pc_redirect !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s quiet got wb_en=%0b redir=%0b stall=%0b req=%0b exp 0/0/0/0",
                     tag, wb_en, pc_redirect, stall, mem_req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(blank());
        ex_valid = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        #12;
        checks++;
        if ({mem_req, mem_we, wb_en, pc_redirect, stall} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
            wb_rd !== '0 || wb_data !== '0 || pc_target !== '0) begin
            errors++;
            $display("FAIL reset_state got req=%0b we=%0b wb_en=%0b redir=%0b stall=%0b addr=%h wd=%h rd=%0d data=%h tgt=%h exp all 0",
                     mem_req, mem_we, wb_en, pc_redirect, stall, mem_addr, mem_wdata, wb_rd, wb_data, pc_target);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu_op();
        instr_t t;
        t = blank(); t.rw = 1; t.rd = 5; t.alu = 32'h0000_002A;
        do_alu(t, "alu_op");
        step();
        check_quiet("alu_pulse");
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_quiet("idle_ready_ignored");
    endtask

    task automatic test_load_delay();
        instr_t t;
        t = blank(); t.mr = 1; t.rw = 1; t.m2r = 1; t.rd = 9; t.alu = 32'h100;
        do_mem(t, 3, 32'hDEAD_BEEF, "load_delay3");
    endtask

    task automatic test_branches();
        instr_t t;
        t = blank(); t.bz = 1; t.z = 1; t.rs = 32'h40;
        do_alu(t, "bz_taken");
        t.z = 0;
        do_alu(t, "bz_not_taken");
        t = blank(); t.bn = 1; t.n = 1; t.rs = 32'h44;
        do_alu(t, "bn_taken");
        t = blank(); t.j = 1; t.bz = 1; t.z = 1; t.rs = 32'h48;
        do_alu(t, "jump_and_branch");
        step();
        check_quiet("redirect_pulse");
    endtask

    task automatic test_jump_mem();
        instr_t t;
        t = blank(); t.jm = 1; t.rs = 32'h80; t.alu = 32'h1234;
        do_mem(t, 1, 32'h200, "jump_mem");
    endtask

    task automatic test_savepc();
        instr_t t;
        t = blank(); t.sp = 1; t.rw = 1; t.pc = 32'hFFFF_FFFC; t.imm = 32'd8; t.rd = 3; t.alu = 32'h5555;
        do_alu(t, "savepc_wrap");
    endtask

    task automatic test_reset_mid_mem();
        instr_t t;
        t = blank(); t.mr = 1; t.rw = 1; t.m2r = 1; t.rd = 7; t.alu = 32'h300;
        drive(t);
        step();
        ex_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL reset_mid_mem async got req=%0b stall=%0b exp 0/0", mem_req, stall);
        end
        step();
        rst_n = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        step();
        mem_ready = 1'b0;
        check_quiet("reset_mid_mem_after1");
        step();
        check_quiet("reset_mid_mem_after2");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) do_alu(rand_alu(), "b2b_alu");
        do_mem(rand_mem(), 2, $urandom, "b2b_mem");
        do_alu(rand_alu(), "b2b_after_mem");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) do_alu(rand_alu(), "rand_alu");
            else do_mem(rand_mem(), $urandom_range(1, 5), $urandom, "rand_mem");
            if ($urandom_range(0, 2) == 0) begin
                step();
                check_quiet("rand_gap");
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_delay();
        test_branches();
        test_jump_mem();
        test_savepc();
        test_reset_mid_mem();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
